// File: rtl/interp_sched_pkg.sv
// Shared definitions for the interpolator scheduler: position vector, tag layout,
// pipeline depth constant and scheduler FSM states.
package interp_sched_pkg;

    localparam int unsigned PFRAC  = 8;
    localparam int unsigned PWIDTH = 16;

    typedef struct packed {
        logic [PWIDTH-1:0] x;
        logic [PWIDTH-1:0] y;
    } posvec_t;

    localparam int unsigned INTERP_MAX_INFLIGHT = 16;
    localparam int unsigned INTERP_NREQ         = 4;
    localparam int unsigned INTERP_UWIDTH       = 16;

    // Layout of the interpolator user field: requester id above the requester's own tag.
    typedef struct packed {
        logic [$clog2(INTERP_NREQ)-1:0] id;
        logic [INTERP_UWIDTH-1:0]       user;
    } interp_tag_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HELD  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/interp_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after ptr, with wrap.
// Pointer is owned by the caller so it can be advanced only on real acceptance.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    function automatic logic [IDW-1:0] slot(input logic [IDW-1:0] p, input int unsigned i);
        return IDW'((32'(p) + i) % NREQ);
    endfunction

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        if (en) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!any && valid[slot(ptr, i)]) begin
                    any               = 1'b1;
                    grant[slot(ptr, i)] = 1'b1;
                    grant_id          = slot(ptr, i);
                end
            end
        end
    end

endmodule

// File: rtl/interp_sched.sv
// Shares one interpolator among NREQ requesters with round-robin, credit-limited issue,
// tagged result routing and a drain handshake. Optional stats: INTERP_SCHED_STATS_EN.
module interp_sched
    import interp_sched_pkg::*;
#(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned UWIDTH       = 16,
    parameter int unsigned DWIDTH       = 16,
    parameter int unsigned MAX_INFLIGHT = INTERP_MAX_INFLIGHT,
    parameter int unsigned IDW          = $clog2(NREQ),
    parameter int unsigned CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  posvec_t [NREQ-1:0]             req_pos,
    input  logic [NREQ-1:0][UWIDTH-1:0]    req_user,
    input  logic                           drain_req,
    output logic                           drain_ack,
    output logic                           interp_valid,
    output posvec_t                        interp_pos,
    output logic [IDW+UWIDTH-1:0]          interp_user,
    input  logic                           interp_res_valid,
    input  logic [IDW+UWIDTH-1:0]          interp_res_user,
    input  logic [DWIDTH+2*PFRAC-1:0]      interp_res_data,
    output logic [NREQ-1:0]                rsp_valid,
    output logic [DWIDTH+2*PFRAC-1:0]      rsp_data,
    output logic [UWIDTH-1:0]              rsp_user,
    output logic [CW-1:0]                  inflight,
    output logic                           err_underflow
`ifdef INTERP_SCHED_STATS_EN
   ,output logic [NREQ-1:0][31:0]          grant_cnt,
    output logic [31:0]                    stall_cnt
`endif
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    sched_state_t    state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_id;
    logic            grant_en;
    logic            accept;
    logic            res_hit;
    logic [IDW-1:0]  res_id;
    logic [NREQ-1:0] rsp_sel;

    // rst_n gates the grant so req_ready is also zero while reset is held.
    assign grant_en = rst_n && (state == ST_RUN) && !drain_req && (inflight < MAX_CNT);
    assign res_hit  = interp_res_valid && (inflight != '0);
    assign res_id   = interp_res_user[IDW+UWIDTH-1 -: IDW];
    assign rsp_sel  = {{(NREQ-1){1'b0}}, 1'b1} << res_id;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid    (req_valid),
        .ptr      (rr_ptr),
        .en       (grant_en),
        .grant    (req_ready),
        .grant_id (gnt_id),
        .any      (accept)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            rr_ptr        <= '0;
            inflight      <= '0;
            interp_valid  <= 1'b0;
            interp_pos    <= '0;
            interp_user   <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_user      <= '0;
            err_underflow <= 1'b0;
            drain_ack     <= 1'b0;
        end else begin
            interp_valid <= accept;
            if (accept) begin
                interp_pos  <= req_pos[gnt_id];
                interp_user <= {gnt_id, req_user[gnt_id]};
                rr_ptr      <= IDW'((32'(gnt_id) + 32'd1) % NREQ);
            end

            case ({accept, res_hit})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: ;
            endcase
            if (interp_res_valid && inflight == '0)
                err_underflow <= 1'b1;

            rsp_valid <= interp_res_valid ? rsp_sel : '0;
            if (interp_res_valid) begin
                rsp_data <= interp_res_data;
                rsp_user <= interp_res_user[UWIDTH-1:0];
            end

            drain_ack <= (state == ST_HELD) && drain_req;
            case (state)
                ST_RUN:   if (drain_req) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!drain_req)
                        state <= ST_RUN;
                    else if (inflight == '0 && !interp_valid)
                        state <= ST_HELD;
                end
                ST_HELD:  if (!drain_req) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

`ifdef INTERP_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept)
                grant_cnt[gnt_id] <= grant_cnt[gnt_id] + 32'd1;
            if ((state == ST_RUN) && !drain_req && (inflight == MAX_CNT) && (|req_valid))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
